// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Bus widths and hold levels match the core's pipeline control encoding.
package inst_queue_pkg;

  localparam int INST_W           = 32;
  localparam int INST_ADDR_W      = 32;
  localparam int HOLD_FLAG_W      = 3;
  localparam int INST_QUEUE_DEPTH = 4;

  // Hold level at and above which id is frozen and must not consume the head.
  localparam logic [HOLD_FLAG_W-1:0] HOLD_IF = 3'b010;

  localparam logic [INST_W-1:0]      ZERO_WORD = '0;
  localparam logic [INST_ADDR_W-1:0] ZERO_REG  = '0;

  typedef struct packed {
    logic [INST_W-1:0]      inst;
    logic [INST_ADDR_W-1:0] addr;
  } iq_entry_t;

  function automatic logic id_stalled(input logic [HOLD_FLAG_W-1:0] hold);
    return hold >= HOLD_IF;
  endfunction

endpackage

// File: rtl/inst_queue_fifo_mem.sv
// Storage array for the instruction queue: one write port, one asynchronous read port.
// Contents are never reset; validity is tracked entirely by the owner's count.
module inst_queue_fifo_mem
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  iq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output iq_entry_t                rdata
);

  iq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_queue.sv
// Show-ahead instruction queue between pc fetch and id decode.
// Absorbs decode holds, flushes on redirect, and throttles fetch early enough for in-flight reads.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = INST_QUEUE_DEPTH,
  parameter int SKID  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   jump_flag_i,
  input  logic                   jtag_reset_flag_i,
  input  logic [HOLD_FLAG_W-1:0] hold_flag_i,
  input  logic [INST_W-1:0]      inst_i,
  input  logic [INST_ADDR_W-1:0] inst_addr_i,
  input  logic                   inst_valid_i,
  output logic                   fetch_stall_o,
  output logic [INST_W-1:0]      inst_o,
  output logic [INST_ADDR_W-1:0] inst_addr_o,
  output logic                   inst_valid_o,
  output logic                   overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SKID);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          flush, push, pop, we;
  iq_entry_t     head;

  inst_queue_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata ('{inst: inst_i, addr: inst_addr_i}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign inst_valid_o  = (count_q != '0);
  assign inst_o        = inst_valid_o ? head.inst : ZERO_WORD;
  assign inst_addr_o   = inst_valid_o ? head.addr : ZERO_REG;
  assign fetch_stall_o = (count_q >= STALL_CNT);
  assign overflow_o    = overflow_q;

  always_comb begin
    flush      = jump_flag_i | jtag_reset_flag_i;
    pop        = inst_valid_o && !id_stalled(hold_flag_i);
    // A full queue still accepts when the head leaves in the same cycle.
    push       = inst_valid_i && ((count_q < FULL_CNT) || pop);
    we         = push && !flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d    = count_q + CW'(push) - CW'(pop);
      overflow_d = inst_valid_i && !push;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed scenarios with hand values plus a reference FIFO monitor.
module tb_inst_queue;

  localparam logic [2:0] HOLD_RUN  = 3'd0;
  localparam logic [2:0] HOLD_STOP = 3'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic        jtag_reset_flag_i = 1'b0;
  logic [2:0]  hold_flag_i = 3'd0;
  logic [31:0] inst_i = 32'd0;
  logic [31:0] inst_addr_i = 32'd0;
  logic        inst_valid_i = 1'b0;
  logic        fetch_stall_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(4), .SKID(1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .jump_flag_i       (jump_flag_i),
    .jtag_reset_flag_i (jtag_reset_flag_i),
    .hold_flag_i       (hold_flag_i),
    .inst_i            (inst_i),
    .inst_addr_i       (inst_addr_i),
    .inst_valid_i      (inst_valid_i),
    .fetch_stall_o     (fetch_stall_o),
    .inst_o            (inst_o),
    .inst_addr_o       (inst_addr_o),
    .inst_valid_o      (inst_valid_o),
    .overflow_o        (overflow_o)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic        exp_ovf = 1'b0;
  logic        m_pop, m_push;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle compare of outputs against the reference, then advance it by this cycle's inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      check("rst_valid", 64'(inst_valid_o), 64'd0);
      check("rst_data", {inst_o, inst_addr_o}, 64'd0);
      check("rst_stall", 64'(fetch_stall_o), 64'd0);
      check("rst_ovf", 64'(overflow_o), 64'd0);
    end else begin
      check("valid", 64'(inst_valid_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("head", {inst_o, inst_addr_o}, exp_q[0]);
      else                   check("empty_zero", {inst_o, inst_addr_o}, 64'd0);
      check("stall", 64'(fetch_stall_o), 64'(exp_q.size() >= 3));
      check("overflow", 64'(overflow_o), 64'(exp_ovf));
      m_pop  = (exp_q.size() != 0) && (hold_flag_i < 3'd2);
      m_push = inst_valid_i && ((exp_q.size() < 4) || m_pop);
      if (jump_flag_i || jtag_reset_flag_i) begin
        exp_q.delete();
        exp_ovf = 1'b0;
      end else begin
        exp_ovf = inst_valid_i && !m_push;
        if (m_pop)  void'(exp_q.pop_front());
        if (m_push) exp_q.push_back({inst_i, inst_addr_i});
      end
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
  task automatic cyc(input logic v, input logic [31:0] i, input logic [31:0] a,
                     input logic [2:0] h, input logic j, input logic t);
    inst_valid_i      = v;
    inst_i            = i;
    inst_addr_i       = a;
    hold_flag_i       = h;
    jump_flag_i       = j;
    jtag_reset_flag_i = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [31:0] i, input logic [31:0] a);
    check({name, "_valid"}, 64'(inst_valid_o), 64'd1);
    check({name, "_head"}, {inst_o, inst_addr_o}, {i, a});
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: back-to-back pushes drain in order one per cycle
    cyc(1, 32'h0000_0013, 32'h0, HOLD_RUN, 0, 0);
    chk_head("t1_a", 32'h0000_0013, 32'h0);
    cyc(1, 32'h0010_0093, 32'h4, HOLD_RUN, 0, 0);
    chk_head("t1_b", 32'h0010_0093, 32'h4);
    cyc(0, 32'h0, 32'h0, HOLD_RUN, 0, 0);
    check("t1_empty", 64'(inst_valid_o), 64'd0);

    // 2: held decode fills the queue; stall at 3, overflow pulse on 5th push
    for (int k = 0; k < 4; k++) begin
      cyc(1, 32'hD000_0000 + k, 32'h100 + 4 * k, HOLD_STOP, 0, 0);
      check("t2_stall", 64'(fetch_stall_o), 64'(k >= 2));
      chk_head("t2", 32'hD000_0000, 32'h100);
    end
    cyc(1, 32'hDEAD_BEEF, 32'h200, HOLD_STOP, 0, 0);
    check("t2_ovf_pulse", 64'(overflow_o), 64'd1);
    chk_head("t2_keep", 32'hD000_0000, 32'h100);
    cyc(0, 32'h0, 32'h0, HOLD_STOP, 0, 0);
    check("t2_ovf_clear", 64'(overflow_o), 64'd0);

    // 3: full queue, push and pop together
    cyc(1, 32'hD000_0004, 32'h110, HOLD_RUN, 0, 0);
    check("t3_ovf", 64'(overflow_o), 64'd0);
    check("t3_stall", 64'(fetch_stall_o), 64'd1);
    chk_head("t3_d1", 32'hD000_0001, 32'h104);
    for (int k = 2; k <= 4; k++) begin
      cyc(0, 32'h0, 32'h0, HOLD_RUN, 0, 0);
      chk_head("t3_drain", 32'hD000_0000 + k, 32'h100 + 4 * k);
    end
    cyc(0, 32'h0, 32'h0, HOLD_RUN, 0, 0);
    check("t3_empty", 64'(inst_valid_o), 64'd0);

    // 4: jump flush discards queued entries and the concurrent push
    for (int k = 0; k < 3; k++) cyc(1, 32'hE000_0000 + k, 32'h300 + 4 * k, HOLD_STOP, 0, 0);
    cyc(1, 32'hE000_0003, 32'h30C, HOLD_STOP, 1, 0);
    check("t4_valid", 64'(inst_valid_o), 64'd0);
    check("t4_zero", {inst_o, inst_addr_o}, 64'd0);
    cyc(0, 32'h0, 32'h0, HOLD_STOP, 0, 0);
    check("t4_discard", 64'(inst_valid_o), 64'd0);

    // 5: async reset mid-cycle with two entries queued
    cyc(1, 32'hF000_0000, 32'h400, HOLD_STOP, 0, 0);
    cyc(1, 32'hF000_0001, 32'h404, HOLD_STOP, 0, 0);
    inst_valid_i = 1'b0;
    hold_flag_i  = HOLD_RUN;
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 64'(inst_valid_o), 64'd0);
    check("t5_async_zero", {inst_o, inst_addr_o}, 64'd0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 32'hF000_0002, 32'h408, HOLD_RUN, 0, 0);
    chk_head("t5_new", 32'hF000_0002, 32'h408);

    // 6: random push/hold/flush traffic checked by the monitor every cycle
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 1)), $urandom(), 32'h1000 + 4 * n, 3'($urandom_range(0, 3)),
          $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (6) cyc(0, 32'h0, 32'h0, HOLD_RUN, 0, 0);
    check("final_empty", 64'(inst_valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
